// File: rtl/ripple_pkg.sv
// Shared definitions for the ripple accumulator block.
//   state_e    : accumulator FSM states (idle, accumulating, result ready)
//   DefaultN   : default operand / accumulator width in bits
//   DefaultLen : default number of operands per frame
package ripple_pkg;

    localparam int unsigned DefaultN   = 4;
    localparam int unsigned DefaultLen = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

endpackage

// File: rtl/ripple_carry.sv
// Parameterised N-bit ripple-carry adder built from a chain of full adders.
// Ports:
//   a, b : N-bit addends
//   cin  : carry into bit 0
//   sum  : N-bit sum (a + b + cin) modulo 2^N
//   cout : carry out of the most significant bit
module ripple_carry #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < N; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[N];

endmodule

// File: rtl/ripple_accumulator.sv
// Frame accumulator: sums LEN unsigned N-bit operands into an N-bit result
// (modulo 2^N) and flags whether any addition in the frame carried out.
// Ports:
//   clk       : clock, rising edge
//   rst_n     : asynchronous active-low reset
//   flush     : synchronous frame abort (wins over any handshake that cycle)
//   in_valid  : in_data is valid
//   in_ready  : operand accepted this cycle when in_valid is also high
//   in_data   : N-bit unsigned operand
//   out_valid : frame result available
//   out_ready : consumer takes the result
//   out_sum   : registered frame sum modulo 2^N
//   out_ovf   : registered sticky carry-out flag for the frame
module ripple_accumulator
    import ripple_pkg::*;
#(
    parameter int unsigned N   = DefaultN,
    parameter int unsigned LEN = DefaultLen
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_sum,
    output logic         out_ovf
);

    localparam int unsigned     CntW   = $clog2(LEN + 1);
    localparam logic [CntW-1:0] LenCnt = CntW'(LEN);

    state_e          state_q, state_d;
    logic [N-1:0]    acc_q, acc_d;
    logic            ovf_q, ovf_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [CntW-1:0] cnt_inc;
    logic [N-1:0]    add_sum;
    logic            add_cout;
    logic            accept;

    ripple_carry #(
        .N(N)
    ) u_adder (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    assign accept  = in_valid & in_ready;
    assign cnt_inc = cnt_q + CntW'(1);

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (flush) begin
            // Abort discards any beat or result handshake in the same cycle.
            state_d = StIdle;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    if (accept) begin
                        acc_d   = add_sum;
                        ovf_d   = ovf_q | add_cout;
                        cnt_d   = cnt_inc;
                        state_d = (cnt_inc == LenCnt) ? StDone : StAccum;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_d = StIdle;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        in_ready  = (state_q != StDone);
        out_valid = (state_q == StDone);
        out_sum   = acc_q;
        out_ovf   = ovf_q;
    end

endmodule

// File: tb/tb_ripple_accumulator.sv
// Self-checking bench for ripple_accumulator (N=4, LEN=4): directed frames
// followed by randomized traffic, compared every cycle against a frame model.
module tb_ripple_accumulator;

    localparam int unsigned N   = 4;
    localparam int unsigned LEN = 4;

    logic         clk;
    logic         rst_n;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_sum;
    logic         out_ovf;

    int checks;
    int failures;

    // Reference: operands accepted in the current frame, and whether the
    // frame is complete and waiting for the consumer.
    int unsigned beats[$];
    bit          pending;

    ripple_accumulator #(
        .N   (N),
        .LEN (LEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned model_sum();
        int unsigned s;
        s = 0;
        foreach (beats[i]) s += beats[i];
        return s % (1 << N);
    endfunction

    // Carry-out happens whenever the running total wraps past 2^N.
    function automatic bit model_ovf();
        int unsigned r;
        bit          o;
        r = 0;
        o = 1'b0;
        foreach (beats[i]) begin
            r += beats[i];
            if (r >= (1 << N)) begin
                o = 1'b1;
                r -= (1 << N);
            end
        end
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        beats.delete();
        pending = 1'b0;
    endtask

    // One clock: drive inputs at the falling edge, check registered outputs
    // against the model, then advance the model at the rising edge.
    task automatic step(input logic f, input logic iv, input logic [N-1:0] d, input logic ordy);
        @(negedge clk);
        flush     = f;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        chk("in_ready", 32'(in_ready), 32'(!pending));
        chk("out_valid", 32'(out_valid), 32'(pending));
        chk("out_sum", 32'(out_sum), model_sum());
        chk("out_ovf", 32'(out_ovf), 32'(model_ovf()));
        @(posedge clk);
        if (f) begin
            model_clear();
        end else if (pending) begin
            if (ordy) model_clear();
        end else if (iv) begin
            beats.push_back(int'(d));
            if (beats.size() == LEN) pending = 1'b1;
        end
    endtask

    // Result check against hand-derived constants, just after the edge.
    task automatic check_done(input string tag, input logic [N-1:0] s, input logic o);
        #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        chk({tag, "_sum"}, 32'(out_sum), 32'(s));
        chk({tag, "_ovf"}, 32'(out_ovf), 32'(o));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_sum"}, 32'(out_sum), 32'd0);
        chk({tag, "_ovf"}, 32'(out_ovf), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        model_clear();

        do_reset("reset");
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);

        // out_ready high with nothing pending has no effect
        step(1'b0, 1'b0, 4'd0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);

        // 3+1+5+2 = 11, no carry; a beat offered during the handshake is ignored
        step(1'b0, 1'b1, 4'd3, 1'b1);
        step(1'b0, 1'b1, 4'd1, 1'b1);
        step(1'b0, 1'b1, 4'd5, 1'b1);
        step(1'b0, 1'b1, 4'd2, 1'b1);
        check_done("f1", 4'b1011, 1'b0);
        step(1'b0, 1'b1, 4'd9, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b0);

        // 15+1 wraps to 0 with a sticky carry; consumer stalls 3 cycles
        step(1'b0, 1'b1, 4'd15, 1'b0);
        step(1'b0, 1'b1, 4'd1, 1'b0);
        step(1'b0, 1'b1, 4'd0, 1'b0);
        step(1'b0, 1'b1, 4'd0, 1'b0);
        check_done("f2", 4'd0, 1'b1);
        step(1'b0, 1'b1, 4'd7, 1'b0);
        step(1'b0, 1'b1, 4'd7, 1'b0);
        step(1'b0, 1'b1, 4'd7, 1'b0);
        check_done("f2_stall", 4'd0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);

        // Flush after two beats, the beat alongside flush is dropped
        step(1'b0, 1'b1, 4'd7, 1'b0);
        step(1'b0, 1'b1, 4'd7, 1'b0);
        step(1'b1, 1'b1, 4'd3, 1'b0);
        step(1'b0, 1'b1, 4'd1, 1'b0);
        step(1'b0, 1'b1, 4'd1, 1'b0);
        step(1'b0, 1'b1, 4'd1, 1'b0);
        step(1'b0, 1'b1, 4'd1, 1'b0);
        check_done("f3", 4'd4, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1);

        // in_valid toggling each cycle
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'd2, 1'b0);
            if (i < 3) step(1'b0, 1'b0, 4'd5, 1'b0);
        end
        check_done("f4", 4'd8, 1'b0);
        step(1'b0, 1'b0, 4'd0, 1'b1);

        // Reset mid-frame discards the partial frame
        step(1'b0, 1'b1, 4'd4, 1'b0);
        step(1'b0, 1'b1, 4'd4, 1'b0);
        step(1'b0, 1'b1, 4'd4, 1'b0);
        do_reset("midreset");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'd4, 1'b0);
        check_done("f5", 4'd0, 1'b1);
        step(1'b0, 1'b0, 4'd0, 1'b1);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 1) == 1));
        end
        step(1'b0, 1'b0, 4'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ripple_accumulator.md
RIPPLE_ACCUMULATOR -- requirements
Module: ripple_accumulator

Interface
REQ-001 SHALL have parameter N, default 4: operand and accumulator width in bits (N >= 1).
REQ-002 SHALL have parameter LEN, default 4: operands per frame (LEN >= 1).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port flush, input, 1 bit: synchronous frame abort, active high.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts an operand this cycle.
REQ-008 SHALL have port in_data, input, N bits: unsigned operand.
REQ-009 SHALL have port out_valid, output, 1 bit: frame result is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port out_sum, output, N bits: frame sum modulo 2^N.
REQ-012 SHALL have port out_ovf, output, 1 bit: at least one addition in the frame produced a carry-out.

Function
REQ-013 SHALL accept an input beat only in a cycle where in_valid and in_ready are both 1.
REQ-014 SHALL implement three states: IDLE, ACCUM and DONE.
REQ-015 SHALL drive in_ready = 1 in IDLE and ACCUM, and 0 in DONE.
REQ-016 SHALL, on each accepted beat, update acc <= acc + in_data using the ripple adder with cin = 0, keeping the low N bits.
REQ-017 SHALL, on each accepted beat, set ovf <= ovf | carry-out, and increment cnt (width $clog2(LEN+1)).
REQ-018 SHALL move from IDLE to ACCUM on the first accepted beat, or directly to DONE when LEN == 1.
REQ-019 SHALL move from ACCUM to DONE on the beat that makes cnt equal LEN.
REQ-020 SHALL leave state, acc, ovf and cnt unchanged on any cycle with no accepted beat, so in_valid gaps are tolerated.
REQ-021 SHALL assert out_valid in DONE only, starting the cycle after the LEN-th beat is accepted (1-cycle latency).
REQ-022 SHALL drive out_sum = acc and out_ovf = ovf as registered values.
REQ-023 SHALL hold out_sum and out_ovf stable while out_valid = 1 and out_ready = 0.
REQ-024 SHALL, on out_valid and out_ready both 1, return to IDLE and clear acc, ovf and cnt to 0, with out_valid = 0 the next cycle.
REQ-025 SHALL, on flush = 1 in any state, go to IDLE and clear acc, ovf and cnt.
REQ-026 SHALL give flush priority over any simultaneous input beat or output handshake in that cycle; that beat is discarded.
REQ-027 SHALL NOT accept input in the cycle the output handshake completes; the next frame starts in IDLE at the earliest one cycle later.
REQ-028 SHALL tolerate out_ready = 1 while out_valid = 0 with no effect.

Reset
REQ-029 SHALL, while rst_n = 0, force state = IDLE, acc = 0, ovf = 0 and cnt = 0.
REQ-030 SHALL, while rst_n = 0, drive out_valid = 0, out_sum = 0 and out_ovf = 0; in_ready SHALL read 1 after reset release.
REQ-031 SHALL discard any partial frame when reset asserts mid-frame; no result is produced for it.

Structure
REQ-032 SHALL take the state enum (IDLE, ACCUM, DONE) and default N/LEN constants from a shared package, ripple_pkg.
REQ-033 SHALL instantiate the existing parameterised ripple-carry adder as its single sub-module (ripple_carry, N-bit, cin tied to 0) for the acc + in_data path.
REQ-034 SHALL keep the FSM and registers in this module; no other sub-modules.

Verification (N=4, LEN=4)
REQ-035 SHALL cover: beats 3, 1, 5, 2 with out_ready = 1 -> out_sum = 4'b1011, out_ovf = 0, out_valid high one cycle after beat 4.
REQ-036 SHALL cover: beats 15, 1, 0, 0 -> out_sum = 0, out_ovf = 1 (sticky through the later zero beats).
REQ-037 SHALL cover: out_ready held low 3 cycles in DONE -> out_valid = 1, in_ready = 0 and out_sum stable; a beat offered then is not consumed.
REQ-038 SHALL cover: flush after 2 beats (7, 7), then beats 1, 1, 1, 1 -> out_sum = 4, out_ovf = 0.
REQ-039 SHALL cover: in_valid toggled 1/0 each cycle with beats 2, 2, 2, 2 -> out_sum = 8, arriving 1 cycle after the 4th accepted beat.
REQ-040 SHALL cover: rst_n pulsed low after 3 beats -> all outputs 0; the next full frame 4, 4, 4, 4 -> out_sum = 0, out_ovf = 1.
